slc3_mem_responder: RTL

Memory-side responder for the SLC-3 CPU memory bus. It answers the CPU's active-low chip-enable, output-enable and write-enable requests with word reads and writes, after a programmable number of wait states. It completes each access with a one-cycle ready pulse (R). It replaces the zero-latency board SRAM model in simulation and on-chip RAM builds, so the CPU's memory-wait states are actually exercised.

---
 rtl/slc3_mem_responder.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/slc3_mem_responder.sv
// ---------------------------------------------------------------------------
// slc3_mem_responder
//
// Memory-side responder for the SLC-3 CPU memory bus. It accepts an
// active-low CE/OE/WE request, waits WAIT_STATES cycles, then performs one
// 16-bit word read or write. Completion is marked by a one-cycle R pulse.
// A request that stays asserted is served once. It must deassert before the
// next request is accepted.
//
// Parameters:
//   ADDR_W       implemented word-address bits (depth 2^ADDR_W x 16)
//   WAIT_STATES  cycles between accepting a request and performing it (0..15)
//
// Ports:
//   Clk             in   system clock, rising edge
//   Reset_n         in   asynchronous active-low reset
//   Mem_CE          in   chip enable, active-low
//   Mem_OE          in   read request, active-low
//   Mem_WE          in   write request, active-low (wins over Mem_OE)
//   Mem_UB, Mem_LB  in   byte-lane enables, active-low (SLC3_BYTE_LANE_EN only)
//   ADDR[19:0]      in   word address
//   Data_to_SRAM    in   write data
//   Data_from_SRAM  out  read data, held until the next read completes
//   R               out  one-cycle completion pulse
//   Busy            out  request accepted but not yet complete
//
// Build option:
//   SLC3_BYTE_LANE_EN  adds the Mem_UB/Mem_LB byte-lane enables.
// ---------------------------------------------------------------------------
module slc3_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Mem_CE,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
`ifdef SLC3_BYTE_LANE_EN
    input  logic        Mem_UB,
    input  logic        Mem_LB,
`endif
    input  logic [19:0] ADDR,
    input  logic [15:0] Data_to_SRAM,
    output logic [15:0] Data_from_SRAM,
    output logic        R,
    output logic        Busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              r_q, r_d;
    logic [15:0]       dout_q;

    // Request captured in IDLE
    logic [ADDR_W-1:0] addr_q;
    logic              oor_q;
    logic              we_q;
    logic [15:0]       data_q;
    logic              ub_q, lb_q;

    logic              req;
    logic              in_oor;
    logic              latch;
    logic              do_access;

    // Operation actually performed on entry to ACCESS
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_oor, acc_we, acc_ub, acc_lb;
    logic [15:0]       acc_data;
    logic [15:0]       lane_mask;

    logic [15:0]       mem [0:(1<<ADDR_W)-1];

    assign req    = ~Mem_CE & (~Mem_OE | ~Mem_WE);
    // Any set bit above the implemented range makes the access a no-op.
    assign in_oor = (ADDR >> ADDR_W) != 20'd0;

    // With zero wait states the access happens on the sampling edge itself,
    // so the live inputs are used instead of the not-yet-latched copies.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_addr = ADDR[ADDR_W-1:0];
            acc_oor  = in_oor;
            acc_we   = ~Mem_WE;
            acc_data = Data_to_SRAM;
        end else begin
            acc_addr = addr_q;
            acc_oor  = oor_q;
            acc_we   = we_q;
            acc_data = data_q;
        end
    end

`ifdef SLC3_BYTE_LANE_EN
    assign acc_ub = (state_q == S_IDLE) ? ~Mem_UB : ub_q;
    assign acc_lb = (state_q == S_IDLE) ? ~Mem_LB : lb_q;
`else
    assign acc_ub = 1'b1;
    assign acc_lb = 1'b1;
`endif

    assign lane_mask = {{8{acc_ub}}, {8{acc_lb}}};

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        r_d       = 1'b0;
        latch     = 1'b0;
        do_access = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    latch  = 1'b1;
                    busy_d = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d   = S_ACCESS;
                        r_d       = 1'b1;
                        do_access = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            S_WAIT: begin
                // Only chip enable is watched here; dropping it aborts.
                if (Mem_CE) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    state_d   = S_ACCESS;
                    r_d       = 1'b1;
                    do_access = 1'b1;
                    cnt_d     = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                state_d = S_HOLD;
                busy_d  = 1'b0;
            end
            default: begin
                // HOLD: a request left asserted never retriggers.
                if (!req) state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            r_q     <= 1'b0;
            addr_q  <= '0;
            oor_q   <= 1'b0;
            we_q    <= 1'b0;
            data_q  <= 16'h0000;
            ub_q    <= 1'b1;
            lb_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            r_q     <= r_d;
            if (latch) begin
                addr_q <= ADDR[ADDR_W-1:0];
                oor_q  <= in_oor;
                we_q   <= ~Mem_WE;
                data_q <= Data_to_SRAM;
`ifdef SLC3_BYTE_LANE_EN
                ub_q   <= ~Mem_UB;
                lb_q   <= ~Mem_LB;
`endif
            end
        end
    end

    // Read data is registered on entry to ACCESS, so it is valid with R.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dout_q <= 16'h0000;
        end else if (do_access && !acc_we) begin
            dout_q <= acc_oor ? 16'h0000 : (mem[acc_addr] & lane_mask);
        end
    end

    // NOTE: the memory array has no reset; contents survive Reset_n, and a
    // reset-free array maps onto block RAM.
    always_ff @(posedge Clk) begin
        if (do_access && acc_we && !acc_oor) begin
            if (acc_ub) mem[acc_addr][15:8] <= acc_data[15:8];
            if (acc_lb) mem[acc_addr][7:0]  <= acc_data[7:0];
        end
    end

    assign Data_from_SRAM = dout_q;
    assign R              = r_q;
    assign Busy           = busy_q;

endmodule
